bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double-dabble): inverse of the
//  PC binary-to-BCD display path. Takes DIGITS packed BCD digits (switch/keypad

---
 rtl/bcd_to_bin_seq.sv | 113 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
// Digits above 9 are flagged through err instead of being converted.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WIDTH-1:0]      bin_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t               state_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic [4*DIGITS-1:0]  bcd_d;
    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     bin_d;
    logic [CW-1:0]        cnt_q;
    logic                 errNext_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [WIDTH-1:0]     binOut_q;
    logic                 illegal;

    // One reverse double-dabble step: shift right, then pull every digit that
    // landed at 8 or above back into BCD range by subtracting 3.
    always_comb begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] >= 4'd8) begin
                bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                illegal = 1'b1;
            end
        end
    end

    // done is cleared by default so it only pulses for the single DONE visit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            errNext_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            binOut_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            errNext_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bcd_q     <= bcd_in;
                            bin_q     <= '0;
                            cnt_q     <= CW'(WIDTH);
                            errNext_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    err_q    <= errNext_q;
                    binOut_q <= errNext_q ? '0 : bin_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = binOut_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: timeline reference model compared every
// cycle, plus directed cases with literal expectations and a full 000..999 sweep.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;

    logic              clock;
    logic              reset;
    logic              start;
    logic [11:0]       bcdIn;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  binOut;

    int checks = 0;
    int errors = 0;

    // Reference model state: a timeline of edge numbers rather than an FSM.
    int cyc       = 0;
    int readyCyc  = 0;
    int doneCyc   = -1;
    int busyFrom  = -1;
    int busyTo    = -1;
    int pendBin   = 0;
    bit pendErr   = 0;
    int expBin    = 0;
    bit expErr    = 0;
    bit expDone   = 0;
    bit expBusy   = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcdIn),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (binOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [11:0] enc(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // The model decides from decimal arithmetic what each accepted request yields
    // and on which edges busy/done must be seen; a compare follows every edge.
    always @(posedge clock) begin
        int  val;
        bit  bad;
        int  d;
        cyc++;
        if (reset) begin
            readyCyc = cyc + 1;
            doneCyc  = -1;
            busyFrom = -1;
            busyTo   = -1;
            expBin   = 0;
            expErr   = 0;
        end else begin
            if (cyc == doneCyc) begin
                expBin = pendBin;
                expErr = pendErr;
            end
            if (start && cyc >= readyCyc) begin
                val = 0;
                bad = 0;
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    d = int'((bcdIn >> (4 * i)) & 12'hF);
                    if (d > 9) bad = 1;
                    val = val * 10 + d;
                end
                if (bad) begin
                    pendBin  = 0;
                    pendErr  = 1;
                    doneCyc  = cyc + 1;
                    readyCyc = cyc + 2;
                end else begin
                    pendBin  = val;
                    pendErr  = 0;
                    busyFrom = cyc;
                    busyTo   = cyc + WIDTH;
                    doneCyc  = cyc + WIDTH + 1;
                    readyCyc = cyc + WIDTH + 2;
                end
            end
        end
        expDone = (cyc == doneCyc);
        expBusy = (cyc >= busyFrom) && (cyc < busyTo);
        #1;
        checkOutput("model_done", 32'(done), 32'(expDone));
        checkOutput("model_busy", 32'(busy), 32'(expBusy));
        checkOutput("model_err", 32'(err), 32'(expErr));
        checkOutput("model_bin", 32'(binOut), 32'(expBin));
    end

    // Pulse start for exactly one sampling edge; returns just after that edge.
    task automatic applyStimulus(input logic [11:0] bcd);
        @(negedge clock);
        start = 1'b1;
        bcdIn = bcd;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output int lat, output int busyCnt);
        lat = -1;
        busyCnt = 0;
        for (int k = 1; k <= maxCyc; k++) begin
            @(posedge clock);
            #1;
            if (busy) busyCnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runOne(input string name, input logic [11:0] bcd, input int expLat,
                          input int expBusyCnt, input int expVal, input bit expE);
        int lat;
        int bc;
        int bc0;
        applyStimulus(bcd);
        bc0 = busy ? 1 : 0;
        waitDone(30, lat, bc);
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_busycycles"}, 32'(bc0 + bc), 32'(expBusyCnt));
        checkOutput({name, "_bin"}, 32'(binOut), 32'(expVal));
        checkOutput({name, "_err"}, 32'(err), 32'(expE));
    endtask

    initial begin
        int lat;
        int bc;
        int doneCount;
        int capBin;
        int prevDone;
        int r;

        reset = 1'b1;
        start = 1'b0;
        bcdIn = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_bin", 32'(binOut), 32'd0);

        $display("[TB] directed conversions");
        runOne("t1_999", 12'h999, 11, 10, 999, 1'b0);
        runOne("t2_000", 12'h000, 11, 10, 0, 1'b0);
        runOne("t2_512", 12'h512, 11, 10, 512, 1'b0);
        runOne("t3_1A5", 12'h1A5, 1, 0, 0, 1'b1);
        runOne("t3_042", 12'h042, 11, 10, 42, 1'b0);

        $display("[TB] start ignored while converting");
        applyStimulus(12'h123);
        repeat (3) @(negedge clock);
        start = 1'b1;
        bcdIn = 12'h999;
        @(negedge clock);
        start = 1'b0;
        doneCount = 0;
        capBin = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                doneCount++;
                capBin = int'(binOut);
            end
        end
        checkOutput("t4_donecount", 32'(doneCount), 32'd1);
        checkOutput("t4_bin", 32'(capBin), 32'd123);

        $display("[TB] reset during conversion");
        applyStimulus(12'h777);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_bin", 32'(binOut), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            #1;
            if (done) doneCount++;
        end
        checkOutput("t5_nodone", 32'(doneCount), 32'd0);
        runOne("t5_777", 12'h777, 11, 10, 777, 1'b0);

        $display("[TB] sweep 000..999 with start held");
        @(negedge clock);
        start = 1'b1;
        bcdIn = enc(0);
        prevDone = -1;
        for (int v = 0; v < 1000; v++) begin
            waitDone(20, lat, bc);
            checkOutput("sweep_seen", 32'(lat > 0), 32'd1);
            checkOutput("sweep_bin", 32'(binOut), 32'(v));
            if (v > 0) checkOutput("sweep_spacing", 32'(cyc - prevDone), 32'd12);
            prevDone = cyc;
            @(negedge clock);
            if (v == 999) start = 1'b0;
            else bcdIn = enc(v + 1);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 3));
            bcdIn = (r == 0) ? 12'($urandom) : enc(int'($urandom_range(0, 999)));
        end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
